defuzz_seq: RTL
===============

Name: defuzz_seq

Overview:
- Multi-channel, handshaked successor to the single-channel centroid defuzzifier.
- Takes per-channel weight sum S_w and weighted sum S_wg. Computes G = min(OUT_MAX, floor(S_wg*OUT_MAX / max(S_w,1))) with one shared iterative restoring divider.
- Sits between the rule-aggregation stage and the actuator/register interface.
- Holds the last result per channel for readback.

Parameters:
- W_IN, 16, width of S_w and S_wg.
- W_OUT, 8, width of the result; OUT_MAX < 2**W_OUT is required (elaboration assertion).
- OUT_MAX, 100, full-scale output value.
- NCH, 4, number of channels, >=1.
- CHW, $clog2(NCH) (min 1), channel index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_ch  in  CHW  channel id of the request
- in_sw  in  W_IN  S_w
- in_swg  in  W_IN  S_wg
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_ch  out  CHW  echoed channel id
- out_g  out  W_OUT  result
- out_zero  out  1  request had S_w==0
- g_hold  out  NCH*W_OUT  last accepted result per channel, channel k at bits [k*W_OUT +: W_OUT]
- busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_ch=0, out_g=0, out_zero=0, g_hold=0, busy=0, FSM=IDLE.
- FSM states: IDLE, PREP, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch ch, sw, swg -> PREP.
  - Accept cycle = T.
- PREP (T+1):
  - den = (sw==0)?1:sw; zero flag = (sw==0).
  - N = swg*OUT_MAX, width W_IN+$clog2(OUT_MAX+1).
  - If swg >= den: result = OUT_MAX -> DONE (no division).
  - Else: load the divider -> DIV.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first, exactly W_OUT cycles.
  - Only W_OUT quotient bits are needed because N < den*OUT_MAX < den*2**W_OUT.
  - Last cycle -> DONE.
- DONE:
  - out_valid=1; out_ch/out_g/out_zero stay stable until out_valid&&out_ready.
  - On that handshake: g_hold[ch] <= out_g (only if ch < NCH), then -> IDLE.
  - out_valid falls the next cycle.
- Latency from accept to out_valid:
  - Saturated path: 2 cycles.
  - Divide path: 2+W_OUT cycles (10 at default).
- in_ready=0 in PREP/DIV/DONE; in_valid is ignored there. There is no input buffering and no pipelining of a second request.
- Throughput: one request in flight. Next accept is possible no earlier than the cycle after the output handshake.
- Channel ids >= NCH (non-power-of-2 NCH): computed and echoed normally; g_hold unchanged.
- Truncation: the quotient is floored. The result never exceeds OUT_MAX.
- Reset asserted in any state:
  - Immediate return to reset values.
  - The in-flight request is dropped; no out_valid is produced for it.
  - g_hold is cleared.

Optional Feature:
- Macro: DEFUZZ_ROUND_EN.
- Defined:
  - After DIV, if 2*remainder >= den, the quotient increments by 1, then clamps to OUT_MAX.
  - The rounding step is combinational on the DIV->DONE edge; latency is unchanged.
  - The saturated path is unaffected.
- Undefined: pure floor.

Decomposition:
- Package defuzz_pkg holds:
  - State enum (IDLE, PREP, DIV, DONE).
  - Default OUT_MAX constant.
  - Function num_width(W_IN, OUT_MAX) returning the numerator width.
- Sub-module defuzz_div_iter: iterative restoring divider.
  - Parameterised numerator width, denominator width and quotient-bit count.
  - Interface: start, done, quotient, remainder.
  - The top holds the FSM, handshake and g_hold.

Test Plan:
- Nominal divide: ch=2, S_w=200, S_wg=100 -> out_g=50, out_ch=2, out_zero=0; out_valid at T+10; after handshake g_hold[2]=50, other channels 0.
- Zero denominator:
  - S_w=0, S_wg=0 -> out_g=0, out_zero=1 (divide path, T+10).
  - S_w=0, S_wg=5 -> out_g=100, out_zero=1, out_valid at T+2.
- Saturation: S_w=200, S_wg=300 -> out_g=100, latency 2. Also S_w=S_wg=65535 -> 100.
- Rounding:
  - S_w=3, S_wg=2 -> 66 without DEFUZZ_ROUND_EN, 67 with it.
  - S_w=65535, S_wg=65534 -> 99 without, 100 with it (clamp honoured).
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new data driven.
  - Required: out_g/out_ch stable, in_ready=0, new request not accepted.
  - Release: handshake, then in_ready=1 the next cycle and the request is accepted.
- Reset mid-DIV (T+5): all outputs return to 0 immediately, g_hold cleared, no out_valid for the dropped request. After release a fresh request (S_w=4, S_wg=1) -> 25.

Source files
------------

// File: rtl/defuzz_pkg.sv
// Shared types and helpers for the defuzz_seq centroid defuzzifier.
package defuzz_pkg;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  localparam int OUT_MAX_DEF = 100;

  // Width of S_wg*OUT_MAX without overflow.
  function automatic int num_width(input int w_in, input int out_max);
    return w_in + $clog2(out_max + 1);
  endfunction

endpackage

// File: rtl/defuzz_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, QBITS cycles.
// quotient/remainder are the post-step values, valid in the cycle done is high.
module defuzz_div_iter #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 16,
  parameter int QBITS = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [QBITS-1:0] quotient,
  output logic [DEN_W-1:0] remainder
);
  localparam int CW = $clog2(QBITS + 1);

  logic [DEN_W-1:0] rem_q, den_q;
  logic [QBITS-1:0] lo_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic             act_q;

  logic [DEN_W:0]   rem_sh;
  logic             ge;

  always_comb begin
    rem_sh    = {rem_q, lo_q[QBITS-1]};
    ge        = rem_sh >= {1'b0, den_q};
    remainder = ge ? (rem_sh[DEN_W-1:0] - den_q) : rem_sh[DEN_W-1:0];
    quotient  = (quo_q << 1) | QBITS'(ge);
    done      = act_q && (cnt_q == CW'(QBITS - 1));
  end

  // Caller guarantees num < den*2**QBITS, so the bits above QBITS seed the
  // partial remainder directly without producing quotient bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      den_q <= '0;
      lo_q  <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start) begin
      rem_q <= DEN_W'(num >> QBITS);
      den_q <= den;
      lo_q  <= num[QBITS-1:0];
      quo_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b1;
    end else if (act_q) begin
      rem_q <= remainder;
      lo_q  <= lo_q << 1;
      quo_q <= quotient;
      cnt_q <= cnt_q + CW'(1);
      if (done) act_q <= 1'b0;
    end
  end

endmodule

// File: rtl/defuzz_seq.sv
// Multi-channel handshaked centroid defuzzifier with one shared iterative divider.
// Optional DEFUZZ_ROUND_EN: round-half-up the quotient (clamped to OUT_MAX).
module defuzz_seq
  import defuzz_pkg::*;
#(
  parameter int W_IN    = 16,
  parameter int W_OUT   = 8,
  parameter int OUT_MAX = OUT_MAX_DEF,
  parameter int NCH     = 4,
  parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHW-1:0]     in_ch,
  input  logic [W_IN-1:0]    in_sw,
  input  logic [W_IN-1:0]    in_swg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHW-1:0]     out_ch,
  output logic [W_OUT-1:0]   out_g,
  output logic               out_zero,
  output logic [NCH*W_OUT-1:0] g_hold,
  output logic               busy
);
  localparam int NW = num_width(W_IN, OUT_MAX);

  if (OUT_MAX >= (1 << W_OUT)) begin : g_bad_out_max
    $error("OUT_MAX must be below 2**W_OUT");
  end

  state_t state, nxt;

  logic [CHW-1:0]   ch_q;
  logic [W_IN-1:0]  sw_q, swg_q;
  logic [W_OUT-1:0] g_q;
  logic             zero_q;

  logic [W_IN-1:0]  den;
  logic [NW-1:0]    num;
  logic             sat, start, div_done;
  logic [W_OUT-1:0] div_q, g_div;
  logic [W_IN-1:0]  div_rem;

  always_comb begin
    den = (sw_q == '0) ? W_IN'(1) : sw_q;
    num = NW'(swg_q) * NW'(OUT_MAX);
    sat = swg_q >= den;
  end

`ifdef DEFUZZ_ROUND_EN
  logic [W_OUT:0] q_rnd;
  always_comb begin
    q_rnd = {1'b0, div_q} + (W_OUT+1)'({div_rem, 1'b0} >= {1'b0, den});
    g_div = (q_rnd > (W_OUT+1)'(OUT_MAX)) ? W_OUT'(OUT_MAX) : q_rnd[W_OUT-1:0];
  end
`else
  logic unused_rem;
  assign unused_rem = ^div_rem;
  assign g_div      = div_q;
`endif

  defuzz_div_iter #(.NUM_W(NW), .DEN_W(W_IN), .QBITS(W_OUT)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .den       (den),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = PREP;
      end
      PREP: begin
        start = !sat;
        nxt   = sat ? DONE : DIV;
      end
      DIV:  if (div_done) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q   <= '0;
      sw_q   <= '0;
      swg_q  <= '0;
      g_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        ch_q  <= in_ch;
        sw_q  <= in_sw;
        swg_q <= in_swg;
      end
      if (state == PREP) begin
        zero_q <= (sw_q == '0);
        if (sat) g_q <= W_OUT'(OUT_MAX);
      end
      if (state == DIV && div_done) g_q <= g_div;
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_ch    = ch_q;
  assign out_g     = g_q;
  assign out_zero  = zero_q;

  // Out-of-range channel ids match no slot, so g_hold is left untouched.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [W_OUT-1:0] hold_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_q <= '0;
      else if (out_valid && out_ready && ch_q == CHW'(k)) hold_q <= g_q;
    end
    assign g_hold[k*W_OUT +: W_OUT] = hold_q;
  end

endmodule
